// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared FSM encoding and defaults for spi_arbiter
//
// Purpose: state encoding and the default transfer timeout shared by the
// arbiter top and its bench.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin requester pick
//
// Purpose: choose the first set request bit searching upward from
// (last_grant + 1) mod N_REQ with wrap-around.
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  IDX_W  index granted most recently
//   grant      out IDX_W  chosen index (0 when nothing requested)
//   valid      out 1      at least one request bit set
module spi_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  // Scan from the lowest priority candidate (last_grant itself) up to the
  // highest (last_grant + 1); later hits overwrite earlier ones, so the
  // surviving value is the first set bit in round-robin order.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin : scan
      int idx;
      idx = (int'(last_grant) + k) % N_REQ;
      if (req[idx]) begin
        grant = IDX_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one spi_master among N_REQ requesters
//
// Purpose: grant one requester at a time, run a single byte transfer on the
// shared spi_master, return the received byte with a one-cycle ack (plus err
// on timeout) and route the master chip select to the granted slave.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req, req_data          per-requester request and flat TX bytes
//   ack, err, rsp_data     completion pulse, timeout pulse, received byte
//   m_start, m_tx_data     start pulse and TX byte to spi_master
//   m_done, m_rx_data      completion pulse and RX byte from spi_master
//   m_cs                   spi_master chip select (active low)
//   cs_n                   per-slave chip selects
//   busy                   high whenever the FSM is not idle
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rsp_data,
  output logic               m_start,
  output logic [7:0]         m_tx_data,
  input  logic               m_done,
  input  logic [7:0]         m_rx_data,
  input  logic               m_cs,
  output logic [N_REQ-1:0]   cs_n,
  output logic               busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             m_start_q, m_start_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] pick_grant;
  logic             pick_valid;

  spi_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_d         = tx_q;
    rsp_d        = rsp_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    err_d        = '0;
    m_start_d    = 1'b0;
    cnt_inc      = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_grant;
          tx_d      = req_data[{pick_grant, 3'b000} +: 8];
          m_start_d = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // m_done takes priority over a timeout landing in the same cycle.
        // ack/err are registered here so they appear during RESP.
        if (m_done) begin
          rsp_d          = m_rx_data;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            rsp_d          = 8'h00;
            ack_d[grant_q] = 1'b1;
            err_d[grant_q] = 1'b1;
            state_d        = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      tx_q         <= 8'h00;
      rsp_q        <= 8'h00;
      cnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      m_start_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_q         <= tx_d;
      rsp_q        <= rsp_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      m_start_q    <= m_start_d;
      busy_q       <= busy_d;
    end
  end

  // Chip selects are the one combinational output: the master's select is
  // passed straight through to the granted slave so SPI timing is untouched.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cs_n[i] = 1'b1;
      if ((state_q != ST_IDLE) && (grant_q == IDX_W'(i))) begin
        cs_n[i] = m_cs;
      end
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rsp_data  = rsp_q;
  assign m_start   = m_start_q;
  assign m_tx_data = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - scoreboard bench for spi_arbiter
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack, err, cs_n;
  logic [7:0]     rsp_data, m_tx_data, m_rx_data;
  logic           m_start, m_done, m_cs, busy;

  typedef struct {
    int         g;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_g = -1;
  int   ack_seen = 0;
  bit   auto_drop = 1'b1;
  bit   mute = 1'b0;

  always #5 clk = ~clk;

  spi_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .err       (err),
    .rsp_data  (rsp_data),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_done    (m_done),
    .m_rx_data (m_rx_data),
    .m_cs      (m_cs),
    .cs_n      (cs_n),
    .busy      (busy)
  );

  // spi_master model: the slave answers each byte with tx ^ 8'h99.
  initial begin
    m_done = 1'b0;
    m_cs = 1'b1;
    m_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (m_start === 1'b1 && !mute) begin
        m_cs = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2;
        m_rx_data = m_tx_data ^ 8'h99;
        m_done = 1'b1;
        @(posedge clk);
        #2;
        m_done = 1'b0;
        m_cs = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on ack, TX byte check on m_start, chip-select
  // and ack-shape checks every cycle.
  initial begin
    exp_t       e;
    logic [3:0] exp_cs;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && sb.size() > 0) begin
        cur_g = sb[0].g;
        vectors++;
        if (m_tx_data !== sb[0].tx) begin
          miscompares++;
          $display("FAIL m_tx_data: got %h expected %h", m_tx_data, sb[0].tx);
        end
      end
      vectors++;
      if ($countones(ack) > 1 || (ack != '0 && busy !== 1'b1) || (err & ~ack) != '0) begin
        miscompares++;
        $display("FAIL ack_shape: ack=%b err=%b busy=%b", ack, err, busy);
      end
      if (ack != '0) begin
        ack_seen++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          e = sb.pop_front();
          vectors++;
          if (ack !== (4'b0001 << e.g) || err !== (e.err ? (4'b0001 << e.g) : 4'b0000)
              || rsp_data !== e.rx) begin
            miscompares++;
            $display("FAIL response: got ack=%b err=%b rsp=%h expected grant %0d err=%b rsp=%h",
                     ack, err, rsp_data, e.g, e.err, e.rx);
          end
        end
        if (auto_drop) req = req & ~ack;
      end
      for (int i = 0; i < N; i++) begin
        exp_cs[i] = (busy === 1'b1 && i == cur_g) ? m_cs : 1'b1;
      end
      vectors++;
      if (cs_n !== exp_cs) begin
        miscompares++;
        $display("FAIL cs_n: got %b expected %b", cs_n, exp_cs);
      end
    end
  end

  task automatic push_exp(input int g, input bit is_err);
    exp_t e;
    e.g   = g;
    e.tx  = req_data[g*8 +: 8];
    e.rx  = is_err ? 8'h00 : (req_data[g*8 +: 8] ^ 8'h99);
    e.err = is_err;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    sb.delete();
    cur_g = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending busy=%b expected 0 pending idle", name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if (ack !== 4'h0 || err !== 4'h0 || busy !== 1'b0 || m_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ack=%b err=%b busy=%b m_start=%b expected all 0", ack, err, busy, m_start);
    end
    vectors++;
    if (rsp_data !== 8'h00 || m_tx_data !== 8'h00 || cs_n !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_data: got rsp=%h tx=%h cs_n=%b expected 00 00 1111", rsp_data, m_tx_data, cs_n);
    end
    m_done = 1'b1;
    m_rx_data = 8'hFF;
    @(negedge clk);
    m_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_data !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_m_done: got busy=%b rsp=%h expected 0 00", busy, rsp_data);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_data = {$urandom, 8'hA5} ;
    push_exp(0, 1'b0);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    #1;
    vectors++;
    if (m_start !== 1'b1 || m_tx_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL start_latency: got m_start=%b tx=%h expected 1 a5", m_start, m_tx_data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (m_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_width: got m_start=%b expected 0", m_start);
    end
    wait_done("single");
    vectors++;
    if (rsp_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL rsp_hold: got %h expected 3c", rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int n = 0;
    apply_reset();
    req_data = $urandom;
    base = ack_seen;
    auto_drop = 1'b0;
    for (int k = 0; k < 5; k++) push_exp(k % N, 1'b0);
    @(negedge clk);
    req = 4'b1111;
    while (sb.size() != 0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    req = '0;
    auto_drop = 1'b1;
    wait_done("round_robin");
    vectors++;
    if (ack_seen - base != 5) begin
      miscompares++;
      $display("FAIL rr_ack_count: got %0d expected 5", ack_seen - base);
    end
  endtask

  task automatic test_wrap();
    req_data = $urandom;
    push_exp(2, 1'b0);
    @(negedge clk);
    req = 4'b0100;
    wait_done("wrap_setup");
    push_exp(0, 1'b0);
    push_exp(2, 1'b0);
    req = 4'b0101;
    wait_done("wrap");
  endtask

  task automatic test_timeout();
    int n = 0;
    mute = 1'b1;
    req_data = $urandom;
    push_exp(1, 1'b1);
    @(negedge clk);
    req = 4'b0010;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_start !== 1'b1 && n < 20);
    n = 0;
    while (ack === 4'b0000 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != TO + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO + 1);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: got busy=%b expected 0", busy);
    end
    wait_done("timeout");
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    mute = 1'b1;
    req_data = $urandom;
    push_exp(2, 1'b0);
    @(negedge clk);
    req = 4'b0100;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_start !== 1'b1 && n < 20);
    repeat (3) @(posedge clk);
    #1;
    m_cs = 1'b0;
    @(negedge clk);
    vectors++;
    if (cs_n !== 4'b1011) begin
      miscompares++;
      $display("FAIL cs_granted: got %b expected 1011", cs_n);
    end
    base = ack_seen;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (cs_n !== 4'hF || busy !== 1'b0 || ack !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset: got cs_n=%b busy=%b ack=%b expected 1111 0 0000", cs_n, busy, ack);
    end
    sb.delete();
    cur_g = -1;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cs = 1'b1;
    mute = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ack_seen != base) begin
      miscompares++;
      $display("FAIL reset_no_ack: got %0d acks expected 0", ack_seen - base);
    end
    push_exp(0, 1'b0);
    push_exp(2, 1'b0);
    req = 4'b0101;
    wait_done("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one spi_master (2..8).
REQ-002 Parameter: TIMEOUT, 1023, max cycles waiting for m_done before error abort.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: req  in  N_REQ  per-requester transfer request, held high until its ack.
REQ-006 Port: req_data  in  8*N_REQ  flat TX bytes; requester i uses bits [8i+7:8i].
REQ-007 Port: ack  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-008 Port: err  out  N_REQ  one-cycle timeout pulse, coincident with ack.
REQ-009 Port: rsp_data  out  8  received byte, valid in the ack cycle and held until next ack.
REQ-010 Port: m_start  out  1  one-cycle start pulse to spi_master.
REQ-011 Port: m_tx_data  out  8  TX byte to spi_master, stable from m_start until m_done.
REQ-012 Port: m_done  in  1  spi_master completion pulse.
REQ-013 Port: m_rx_data  in  8  spi_master received byte, valid with m_done.
REQ-014 Port: m_cs  in  1  spi_master chip select (active low).
REQ-015 Port: cs_n  out  N_REQ  per-slave chip select; cs_n[g]=m_cs for granted g, others 1.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP; one-hot or binary encoding is free.
REQ-018 IDLE: if any req bit set, latch grant g = first set bit searching from (last_grant+1) mod N_REQ upward with wrap; latch m_tx_data=req_data[g]; go START.
REQ-019 START: m_start=1 for exactly this cycle; go WAIT; clear timeout counter.
REQ-020 WAIT: on m_done, latch rsp_data=m_rx_data, go RESP; else increment counter; when counter reaches TIMEOUT, latch rsp_data=0, set error flag, go RESP.
REQ-021 RESP: ack[g]=1 (and err[g]=1 if error flag) for this one cycle; last_grant=g; go IDLE.
REQ-022 Latency: req sampled in IDLE at cycle t -> m_start at t+1; m_done at cycle d -> ack at d+1.
REQ-023 Minimum spacing between consecutive m_start pulses: m_done-to-m_start = 3 cycles (RESP, IDLE, START).
REQ-024 Requests arriving while busy are not sampled until next IDLE; no request is lost if held.
REQ-025 req[g] deasserted mid-transfer: transfer completes, ack[g] still pulses.
REQ-026 m_done outside WAIT is ignored; m_done and timeout in the same cycle: m_done wins, no err.
REQ-027 cs_n: all ones in IDLE; only cs_n[g] may go low, and only while m_cs low.
REQ-028 Timeout counter width: clog2(TIMEOUT+1); no wrap before TIMEOUT.
REQ-029 At most one ack bit high in any cycle; ack/err never high outside RESP.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, m_start=0, ack=0, err=0, busy=0, rsp_data=0, m_tx_data=0, cs_n=all ones, last_grant=N_REQ-1 (requester 0 wins first), counter=0.
REQ-031 Reset mid-transfer aborts without ack; spi_master is reset by the same rst_n domain.

Structure
REQ-032 Shared package holds the FSM state encoding and the default TIMEOUT constant.
REQ-033 One sub-module: spi_rr_pick (combinational round-robin priority pick: req, last_grant -> grant index, valid).
REQ-034 All outputs registered except cs_n (combinational gate of registered grant with m_cs).

Verification
REQ-035 Reset then req=4'b0001, req_data[7:0]=8'hA5, model returns 8'h3C -> m_tx_data=A5, m_start one cycle after req, ack=0001, rsp_data=3C, err=0.
REQ-036 req=4'b1111 held, four transfers -> grant order 0,1,2,3, then 0 again; exactly one ack per transfer.
REQ-037 last_grant=2, req=4'b0101 -> grant 0 (wrap), next grant 2.
REQ-038 Model never asserts m_done, TIMEOUT=15 -> ack[g] and err[g] together 16 cycles after m_start, rsp_data=00, FSM back to IDLE.
REQ-039 rst_n pulsed low in WAIT -> cs_n=all ones, busy=0 immediately, no ack; next req served by requester 0.
REQ-040 Check cs_n[g] tracks m_cs while granted, other cs_n bits stay 1 for the whole run.
